// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue stage: ALU op encodings,
// MIPS opcode/funct values, the decoded control bundle and its defaults.
package alu_pkg;

    // ALU32Bit operation encodings
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SW       = 6'h2B;

    // Function codes (instr[5:0])
    localparam logic [5:0] FN_MUL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Decoded control bundle produced from opcode/funct
    typedef struct packed {
        logic [3:0] alu_op;
        logic       use_imm;
        logic       imm_signed;
        logic       dest_is_rt;
        logic       regwrite;
        logic       memread;
        logic       illegal;
    } ctrl_t;

    // Unsupported encodings: ADD with no side effects, flagged illegal
    localparam ctrl_t CTRL_ILLEGAL = '{
        alu_op:     ALU_ADD,
        use_imm:    1'b0,
        imm_signed: 1'b0,
        dest_is_rt: 1'b0,
        regwrite:   1'b0,
        memread:    1'b0,
        illegal:    1'b1
    };

    // Build a legal control bundle
    function automatic ctrl_t mk_ctrl(
        input logic [3:0] op,
        input logic       use_imm,
        input logic       imm_signed,
        input logic       dest_is_rt,
        input logic       regwrite,
        input logic       memread
    );
        ctrl_t c;
        c.alu_op     = op;
        c.use_imm    = use_imm;
        c.imm_signed = imm_signed;
        c.dest_is_rt = dest_is_rt;
        c.regwrite   = regwrite;
        c.memread    = memread;
        c.illegal    = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS opcode/funct decoder producing the ALU op and the
// operand/writeback controls consumed by the issue stage.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    ctrl_t ctrl_s;

    // Decode opcode (and funct for R-type / SPECIAL2) into control fields
    always_comb begin
        ctrl_s = CTRL_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  ctrl_s = mk_ctrl(ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                    FN_SUB:  ctrl_s = mk_ctrl(ALU_SUB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                    FN_AND:  ctrl_s = mk_ctrl(ALU_AND, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                    FN_OR:   ctrl_s = mk_ctrl(ALU_OR,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                    FN_SLT:  ctrl_s = mk_ctrl(ALU_SLT, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                    default: ctrl_s = CTRL_ILLEGAL;
                endcase
            end
            OP_SPECIAL2: begin
                if (funct == FN_MUL) begin
                    ctrl_s = mk_ctrl(ALU_MUL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                end else begin
                    ctrl_s = CTRL_ILLEGAL;
                end
            end
            OP_ADDI: ctrl_s = mk_ctrl(ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            OP_SLTI: ctrl_s = mk_ctrl(ALU_SLT, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            OP_ANDI: ctrl_s = mk_ctrl(ALU_AND, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            OP_ORI:  ctrl_s = mk_ctrl(ALU_OR,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            OP_LW:   ctrl_s = mk_ctrl(ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            OP_SW:   ctrl_s = mk_ctrl(ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            // Branches compare rs against rt, so B stays the register operand
            OP_BEQ:  ctrl_s = mk_ctrl(ALU_SUB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            OP_BNE:  ctrl_s = mk_ctrl(ALU_SUB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            default: ctrl_s = CTRL_ILLEGAL;
        endcase
    end

    assign ctrl = ctrl_s;

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage for ALU32Bit: decodes the ID instruction, holds it in
// the ID/EX register, forwards EX/MEM and MEM/WB results onto A/B and
// inserts bubbles on load-use hazards, flushes and downstream holds.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [5:0]    id_opcode,
    input  logic [5:0]    id_funct,
    input  logic [RW-1:0] id_rs_num,
    input  logic [RW-1:0] id_rt_num,
    input  logic [RW-1:0] id_rd_num,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [15:0]   id_imm,
    input  logic          flush,
    input  logic          ex_hold,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic          ex_valid,
    output logic [3:0]    ALUControl,
    output logic [DW-1:0] A,
    output logic [DW-1:0] B,
    output logic [RW-1:0] ex_rd,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_illegal
);

    // Contents of the ID/EX register; an all-zero value is a bubble
    typedef struct packed {
        logic          valid;
        logic [3:0]    alu_op;
        logic          regwrite;
        logic          memread;
        logic          illegal;
        logic          use_imm;
        logic [RW-1:0] rd;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm_ext;
    } ex_t;

    // A producer forwards only if it writes a nonzero register matching num
    function automatic logic fwd_hit(
        input logic          wr,
        input logic [RW-1:0] src_rd,
        input logic [RW-1:0] num
    );
        return wr & (src_rd != {RW{1'b0}}) & (src_rd == num);
    endfunction

    ctrl_t         dec_s;
    logic [DW-1:0] imm_ext_s;
    logic          load_use_s;
    ex_t           ex_load_s;
    ex_t           ex_next_s;
    ex_t           ex_r;
    logic [DW-1:0] a_s;
    logic [DW-1:0] b_s;

    alu_ctrl_decode u_decode (
        .opcode (id_opcode),
        .funct  (id_funct),
        .ctrl   (dec_s)
    );

    // Sign- or zero-extend the 16-bit immediate as the opcode requires
    always_comb begin
        imm_ext_s = {{(DW-16){dec_s.imm_signed & id_imm[15]}}, id_imm};
    end

    // Load-use hazard: the lw in EX produces a register the ID instruction reads.
    // rt is compared for every format, so some I-type stalls are conservative.
    always_comb begin
        load_use_s = ex_r.valid & ex_r.memread & (ex_r.rd != {RW{1'b0}}) & id_valid &
                     ((ex_r.rd == id_rs_num) | (ex_r.rd == id_rt_num));
    end

    // ID handshake: a flush consumes (and discards) the ID instruction
    always_comb begin
        id_ready = (~load_use_s & ~ex_hold) | flush;
    end

    // Assemble the EX contents for an instruction accepted from ID
    always_comb begin
        ex_load_s          = '0;
        ex_load_s.valid    = 1'b1;
        ex_load_s.alu_op   = dec_s.alu_op;
        ex_load_s.regwrite = dec_s.regwrite;
        ex_load_s.memread  = dec_s.memread;
        ex_load_s.illegal  = dec_s.illegal;
        ex_load_s.use_imm  = dec_s.use_imm;
        ex_load_s.rd       = dec_s.dest_is_rt ? id_rt_num : id_rd_num;
        ex_load_s.rs       = id_rs_num;
        ex_load_s.rt       = id_rt_num;
        ex_load_s.rs_data  = id_rs_data;
        ex_load_s.rt_data  = id_rt_data;
        ex_load_s.imm_ext  = imm_ext_s;
    end

    // Next EX contents by priority: flush > hold > load-use bubble > load
    always_comb begin
        ex_next_s = ex_r;
        if (flush) begin
            ex_next_s = '0;
        end else if (ex_hold) begin
            ex_next_s = ex_r;
        end else if (load_use_s) begin
            ex_next_s = '0;
        end else if (id_valid) begin
            ex_next_s = ex_load_s;
        end else begin
            ex_next_s = '0;
        end
    end

    // ID/EX register with synchronous reset to a bubble
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_r <= '0;
        end else begin
            ex_r <= ex_next_s;
        end
    end

    // A operand: EX/MEM result first, then MEM/WB, else the registered rs data.
    // Forward buses are live, so A can change while EX is held.
    always_comb begin
        if (fwd_hit(exmem_regwrite, exmem_rd, ex_r.rs)) begin
            a_s = exmem_result;
        end else if (fwd_hit(memwb_regwrite, memwb_rd, ex_r.rs)) begin
            a_s = memwb_result;
        end else begin
            a_s = ex_r.rs_data;
        end
    end

    // B operand: the immediate wins, otherwise the same forwarding rule on rt
    always_comb begin
        if (ex_r.use_imm) begin
            b_s = ex_r.imm_ext;
        end else if (fwd_hit(exmem_regwrite, exmem_rd, ex_r.rt)) begin
            b_s = exmem_result;
        end else if (fwd_hit(memwb_regwrite, memwb_rd, ex_r.rt)) begin
            b_s = memwb_result;
        end else begin
            b_s = ex_r.rt_data;
        end
    end

    assign A           = a_s;
    assign B           = b_s;
    assign ex_valid    = ex_r.valid;
    assign ALUControl  = ex_r.alu_op;
    assign ex_rd       = ex_r.rd;
    assign ex_regwrite = ex_r.regwrite;
    assign ex_memread  = ex_r.memread;
    assign ex_illegal  = ex_r.illegal;

endmodule
